display_bcd_seq: RTL and testbench

//  Parametrised successor of the stopwatch seven-segment decoder. Converts a binary seconds count to
//  N_DIG BCD digits with a sequential shift-add-3 (double-dabble) FSM. Decodes those digits, plus one

---
 rtl/display_pkg.sv | 33 +++
 rtl/display_bcd_seq_seg7_decod.sv | 31 +++
 rtl/display_bcd_seq.sv | 165 ++++++++++++++++
 tb/tb_display_bcd_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the BCD seven-segment display path: active-low
// segment codes ({a,b,c,d,e,f,g} MSB..LSB), the sequencer state type and
// the decimal threshold helper used for overflow detection.
package display_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  // 10**n, used as the first value that no longer fits in n decimal digits
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/display_bcd_seq_seg7_decod.sv
// Combinational BCD to active-low seven-segment decoder. Codes 10..15 and
// an asserted blank input both produce a dark digit.
module seg7_decod
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] code_o
);

  // Table lookup; anything outside 0..9 stays dark
  always_comb begin
    code_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    code_o = SEG_0;
        4'd1:    code_o = SEG_1;
        4'd2:    code_o = SEG_2;
        4'd3:    code_o = SEG_3;
        4'd4:    code_o = SEG_4;
        4'd5:    code_o = SEG_5;
        4'd6:    code_o = SEG_6;
        4'd7:    code_o = SEG_7;
        4'd8:    code_o = SEG_8;
        4'd9:    code_o = SEG_9;
        default: code_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/display_bcd_seq.sv
// Binary seconds to N_DIG BCD digits via a sequential double-dabble, plus a
// tenths digit, decoded to held active-low seven-segment codes. Provides
// leading-zero blanking, overflow dashes and a one-deep request buffer.
module display_bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_W    = 10,
  parameter int N_DIG    = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [BIN_W-1:0]       seg,
  input  logic [3:0]             dec,
  output logic [7*(N_DIG+1)-1:0] digitos,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int          BCD_W  = 4 * N_DIG;
  localparam int          DIG_W  = 7 * (N_DIG + 1);
  localparam int          CNT_W  = $clog2(BIN_W);
  localparam logic [63:0] THRESH = 64'(pow10(N_DIG));

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    pending_q;
  logic                    ld_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    ovf_q;
  logic                    ovf_cap_q;
  logic [BIN_W-1:0]        bin_q;
  logic [BCD_W-1:0]        bcd_q;
  logic [3:0]              dec_q;
  logic [DIG_W-1:0]        dig_q;
  logic [DIG_W-1:0]        dig_d;
  logic [N_DIG:0][3:0]     dig_bcd;
  logic [N_DIG:0]          dig_blank;
  logic [N_DIG:0][6:0]     code;
  logic                    accept;
  logic                    seg_ovf;

  // Add-3 correction on every BCD nibble of 5 or more, ahead of the shift
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic [3:0]       nib;
    r = b;
    for (int i = 0; i < N_DIG; i++) begin
      nib = b[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      r[4*i +: 4] = nib;
    end
    return r;
  endfunction

  // Display of seg=0, dec=0: tenths and units "0", upper digits per blanking mode
  function automatic logic [DIG_W-1:0] reset_digits();
    logic [DIG_W-1:0] r;
    r = '0;
    for (int i = 0; i <= N_DIG; i++)
      r[7*i +: 7] = (i <= 1 || BLANK_LZ == 0) ? SEG_0 : SEG_BLANK;
    return r;
  endfunction

  assign accept  = (state_q == IDLE) && (enable || pending_q);
  assign seg_ovf = ({{(64-BIN_W){1'b0}}, seg} >= THRESH);

  // Sequencer: IDLE -> CONV (BIN_W shifts) -> LOAD -> IDLE, with one-deep request buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      ld_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= (state_q != IDLE);
      ld_q   <= (state_q == LOAD);
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= CONV;
            cnt_q     <= '0;
            pending_q <= 1'b0;
          end
        end
        CONV: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) state_q <= LOAD;
          if (enable) pending_q <= 1'b1;
        end
        LOAD: begin
          state_q <= IDLE;
          if (enable) pending_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Conversion datapath: capture on accept, otherwise shift-add-3 while converting
  always_ff @(posedge clk) begin
    if (accept) begin
      bin_q     <= seg;
      bcd_q     <= '0;
      dec_q     <= dec;
      ovf_cap_q <= seg_ovf;
    end else if (state_q == CONV) begin
      {bcd_q, bin_q} <= {add3(bcd_q), bin_q} << 1;
    end
  end

  // Digit selection and leading-zero blanking, scanning from the top digit down
  always_comb begin
    logic zero_above;
    dig_bcd    = '0;
    dig_blank  = '0;
    zero_above = 1'b1;
    dig_bcd[0] = dec_q;
    for (int k = N_DIG; k >= 1; k--) begin
      dig_bcd[k]   = bcd_q[4*(k-1) +: 4];
      zero_above   = zero_above && (bcd_q[4*(k-1) +: 4] == 4'd0);
      dig_blank[k] = (BLANK_LZ != 0) && (k > 1) && zero_above;
    end
  end

  for (genvar gi = 0; gi <= N_DIG; gi++) begin : g_dec
    seg7_decod u_dec (
      .bcd_i   (dig_bcd[gi]),
      .blank_i (dig_blank[gi]),
      .code_o  (code[gi])
    );
  end

  // Integer digits become dashes on overflow; tenths always decoded normally
  always_comb begin
    dig_d = '0;
    for (int i = 0; i <= N_DIG; i++)
      dig_d[7*i +: 7] = (i > 0 && ovf_cap_q) ? SEG_DASH : code[i];
  end

  // Output registers: loaded one cycle after LOAD, held until the next update
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q  <= reset_digits();
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= ld_q;
      if (ld_q) begin
        dig_q <= dig_d;
        ovf_q <= ovf_cap_q;
      end
    end
  end

  assign digitos  = dig_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_display_bcd_seq.sv
// Directed bench for display_bcd_seq: a table of conversions checked on two
// instances (blanking on and off), plus back-to-back, hold and reset-abort
// sequences.
module tb_display_bcd_seq;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [9:0]  seg;
  logic [3:0]  dec;
  logic [27:0] dig1, dig0;
  logic        busy1, done1, ovf1;
  logic        busy0, done0, ovf0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_bcd_seq #(.BIN_W(10), .N_DIG(3), .BLANK_LZ(1)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .seg(seg), .dec(dec),
    .digitos(dig1), .busy(busy1), .done(done1), .overflow(ovf1)
  );

  display_bcd_seq #(.BIN_W(10), .N_DIG(3), .BLANK_LZ(0)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .seg(seg), .dec(dec),
    .digitos(dig0), .busy(busy0), .done(done0), .overflow(ovf0)
  );

  typedef struct {
    int         s;
    int         d;
    logic [6:0] e3, e2, e1, e0;
    logic [6:0] z3, z2, z1;
    logic       ov;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One request held for a single cycle; returns edges to done and busy cycle count
  task automatic do_req(input int s, input int d, output int lat, output int bcnt);
    @(negedge clk);
    seg    = 10'(s);
    dec    = 4'(d);
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    lat  = -1;
    bcnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (busy1) bcnt++;
      if (done1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, bcnt, npulse, n2;

    tbl[0] = '{347, 5,  S3, S4, S7, S5,  S3, S4, S7, 1'b0};
    tbl[1] = '{7,   0,  SB, SB, S7, S0,  S0, S0, S7, 1'b0};
    tbl[2] = '{1000, 2, SD, SD, SD, S2,  SD, SD, SD, 1'b1};
    tbl[3] = '{12,  9,  SB, S1, S2, S9,  S0, S1, S2, 1'b0};
    tbl[4] = '{999, 12, S9, S9, S9, SB,  S9, S9, S9, 1'b0};
    tbl[5] = '{0,   0,  SB, SB, S0, S0,  S0, S0, S0, 1'b0};
    tbl[6] = '{100, 3,  S1, S0, S0, S3,  S1, S0, S0, 1'b0};
    tbl[7] = '{1023, 7, SD, SD, SD, S7,  SD, SD, SD, 1'b1};
    tbl[8] = '{5,   15, SB, SB, S5, SB,  S0, S0, S5, 1'b0};

    rst    = 1'b1;
    enable = 1'b0;
    seg    = '0;
    dec    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digitos_lz1", 64'(dig1), 64'({SB, SB, S0, S0}));
    chk("reset_digitos_lz0", 64'(dig0), 64'({S0, S0, S0, S0}));
    chk("reset_busy", 64'(busy1), 64'(0));
    chk("reset_done", 64'(done1), 64'(0));
    chk("reset_overflow", 64'(ovf1), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_req(tbl[i].s, tbl[i].d, lat, bcnt);
      chk($sformatf("latency[%0d]", i), 64'(lat), 64'(12));
      chk($sformatf("busy_cycles[%0d]", i), 64'(bcnt), 64'(11));
      chk($sformatf("digitos_lz1[%0d]", i), 64'(dig1),
          64'({tbl[i].e3, tbl[i].e2, tbl[i].e1, tbl[i].e0}));
      chk($sformatf("digitos_lz0[%0d]", i), 64'(dig0),
          64'({tbl[i].z3, tbl[i].z2, tbl[i].z1, tbl[i].e0}));
      chk($sformatf("overflow[%0d]", i), 64'(ovf1), 64'(tbl[i].ov));
      @(posedge clk);
      #1;
      chk($sformatf("done_pulse_end[%0d]", i), 64'(done1), 64'(0));
    end

    // Hold: no request, outputs frozen and no done pulses
    npulse = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (done1) npulse++;
    end
    chk("hold_done_pulses", 64'(npulse), 64'(0));
    chk("hold_digitos", 64'(dig1), 64'({SB, SB, S5, SB}));

    // Back-to-back: second request arrives during CONV, restart uses latest inputs
    @(negedge clk);
    seg    = 10'd100;
    dec    = 4'd3;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    seg    = 10'd200;
    dec    = 4'd1;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        lat = n;
        break;
      end
    end
    chk("b2b_first_seen", 64'(lat > 0), 64'(1));
    chk("b2b_first_digitos", 64'(dig1), 64'({S1, S0, S0, S3}));
    n2 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        n2 = n;
        break;
      end
    end
    chk("b2b_second_gap", 64'(n2), 64'(12));
    chk("b2b_second_digitos", 64'(dig1), 64'({S2, S0, S0, S1}));

    // Put overflow high, then abort a conversion with reset
    do_req(1000, 2, lat, bcnt);
    chk("pre_abort_overflow", 64'(ovf1), 64'(1));
    @(negedge clk);
    seg    = 10'd555;
    dec    = 4'd5;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(busy1), 64'(0));
    chk("abort_done", 64'(done1), 64'(0));
    chk("abort_overflow", 64'(ovf1), 64'(0));
    chk("abort_digitos_lz1", 64'(dig1), 64'({SB, SB, S0, S0}));
    chk("abort_digitos_lz0", 64'(dig0), 64'({S0, S0, S0, S0}));
    @(negedge clk);
    rst = 1'b0;
    npulse = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (done1 || busy1) npulse++;
    end
    chk("abort_no_activity", 64'(npulse), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
